// File: rtl/lcd_hd44780_responder.sv
// HD44780 bus responder: decodes writer transactions into a 2x16
// character mirror with busy timing, status flags and read-back.
module lcd_hd44780_responder #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       overrun,
  output logic       addr_err
);

  localparam int MAXB = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int CW = $clog2(MAXB + 1);
  localparam logic [CW-1:0] SHORT_C = CW'(BUSY_SHORT);
  localparam logic [CW-1:0] LONG_C  = CW'(BUSY_LONG);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t         state_q, state_d;
  logic [4:0]     swp_q, swp_d;
  logic           en_q, en_d;
  logic           rs_q, rs_d;
  logic           rw_q, rw_d;
  logic [7:0]     dat_q, dat_d;
  logic [4:0]     cur_q, cur_d;
  logic           id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dsp_q, dsp_d;
  logic           con_q, con_d;
  logic           blk_q, blk_d;
  logic           two_q, two_d;
  logic           ovr_q, ovr_d;
  logic           aerr_q, aerr_d;
  logic [7:0]     mem_q [32];
  logic [7:0]     mem_d [32];

  logic       strobe;
  logic [6:0] ddr_a;
  logic       ddr_ok;
  logic [4:0] ddr_cur;

  assign strobe  = en_q && !en;
  assign busy    = (cnt_q != '0);
  assign ddr_a   = dat_q[6:0];
  assign ddr_ok  = (ddr_a[6:4] == 3'b000) || (ddr_a[6:4] == 3'b100);
  assign ddr_cur = {ddr_a[6], ddr_a[3:0]};

  always_comb begin
    en_d    = en;
    rs_d    = rs_q;
    rw_d    = rw_q;
    dat_d   = dat_q;
    state_d = state_q;
    swp_d   = swp_q;
    cur_d   = cur_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    dsp_d   = dsp_q;
    con_d   = con_q;
    blk_d   = blk_q;
    two_d   = two_q;
    ovr_d   = ovr_q;
    aerr_d  = aerr_q;
    mem_d   = mem_q;
    if (en) begin
      rs_d  = rs;
      rw_d  = rw;
      dat_d = data;
    end
    if (busy) cnt_d = cnt_q - CW'(1);
    if (state_q == S_SWEEP) begin
      mem_d[swp_q] = 8'h20;
      swp_d = swp_q + 5'd1;
      if (swp_q == 5'd31) state_d = S_IDLE;
    end
    // status reads bypass the busy check entirely
    if (strobe && !(rw_q && !rs_q)) begin
      if (busy) begin
        ovr_d = 1'b1;
      end else begin
        cnt_d = SHORT_C;
        if (rs_q) begin
          if (!rw_q) mem_d[cur_q] = dat_q;
          cur_d = id_q ? cur_q + 5'd1 : cur_q - 5'd1;
        end else begin
          unique casez (dat_q)
            8'b1???????: begin
              if (ddr_ok) cur_d = ddr_cur;
              else aerr_d = 1'b1;
            end
            8'b01??????: aerr_d = 1'b1;
            8'b001?????: two_d = dat_q[3];
            8'b0001????: begin
              if (!dat_q[3])
                cur_d = dat_q[2] ? cur_q + 5'd1 : cur_q - 5'd1;
            end
            8'b00001???: begin
              dsp_d = dat_q[2];
              con_d = dat_q[1];
              blk_d = dat_q[0];
            end
            8'b000001??: id_d = dat_q[1];
            8'b0000001?: begin
              cur_d = 5'd0;
              cnt_d = LONG_C;
            end
            8'b00000001: begin
              mem_d[0] = 8'h20;
              swp_d    = 5'd1;
              state_d  = S_SWEEP;
              cur_d    = 5'd0;
              id_d     = 1'b1;
              cnt_d    = LONG_C;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      swp_q   <= 5'd0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      dat_q   <= 8'h00;
      cur_q   <= 5'd0;
      id_q    <= 1'b1;
      cnt_q   <= '0;
      dsp_q   <= 1'b0;
      con_q   <= 1'b0;
      blk_q   <= 1'b0;
      two_q   <= 1'b0;
      ovr_q   <= 1'b0;
      aerr_q  <= 1'b0;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
    end else begin
      state_q <= state_d;
      swp_q   <= swp_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      dat_q   <= dat_d;
      cur_q   <= cur_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      dsp_q   <= dsp_d;
      con_q   <= con_d;
      blk_q   <= blk_d;
      two_q   <= two_d;
      ovr_q   <= ovr_d;
      aerr_q  <= aerr_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    bus_out = 8'h00;
    if (en && rw)
      bus_out = rs ? mem_q[cur_q]
                   : {busy, cur_q[4], 2'b00, cur_q[3:0]};
  end

  assign bus_oe     = en && rw;
  assign rd_char    = mem_q[rd_addr];
  assign cursor     = cur_q;
  assign display_on = dsp_q;
  assign cursor_on  = con_q;
  assign blink_on   = blk_q;
  assign two_line   = two_q;
  assign overrun    = ovr_q;
  assign addr_err   = aerr_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: directed test plan
// followed by random transactions against a behavioural panel model.
module tb_lcd_hd44780_responder;

  localparam int BS = 20;
  localparam int BL = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       rs = 1'b0;
  logic       rw = 1'b0;
  logic       en = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       busy;
  logic       display_on;
  logic       cursor_on;
  logic       blink_on;
  logic       two_line;
  logic       overrun;
  logic       addr_err;

  lcd_hd44780_responder #(
    .BUSY_SHORT(BS),
    .BUSY_LONG (BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .rs        (rs),
    .rw        (rw),
    .en        (en),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .cursor    (cursor),
    .busy      (busy),
    .display_on(display_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .two_line  (two_line),
    .overrun   (overrun),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int m_mem [32];
  int m_cur, m_id, m_dsp, m_con, m_blk, m_two, m_ovr, m_aerr;
  int busy_end, clr_edge;
  logic [7:0] rd_val;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h20;
    m_cur = 0; m_id = 1;
    m_dsp = 0; m_con = 0; m_blk = 0; m_two = 0;
    m_ovr = 0; m_aerr = 0;
    busy_end = 0; clr_edge = -1000;
  endtask

  function automatic int step(input int c, input int up);
    return up != 0 ? (c + 1) % 32 : (c + 31) % 32;
  endfunction

  task automatic model_strobe(input bit r, input bit w,
                              input int d, input int p);
    int a;
    if (w && !r) return;
    if (p <= busy_end) begin
      m_ovr = 1;
      return;
    end
    busy_end = p + BS;
    if (r) begin
      if (!w) m_mem[m_cur] = d;
      m_cur = step(m_cur, m_id);
    end else if (d == 0) begin
    end else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h20;
      m_cur = 0; m_id = 1;
      busy_end = p + BL;
      clr_edge = p;
    end else if (d < 4) begin
      m_cur = 0;
      busy_end = p + BL;
    end else if (d < 8) begin
      m_id = (d / 2) % 2;
    end else if (d < 16) begin
      m_dsp = (d / 4) % 2;
      m_con = (d / 2) % 2;
      m_blk = d % 2;
    end else if (d < 32) begin
      if ((d / 8) % 2 == 0) m_cur = step(m_cur, (d / 4) % 2);
    end else if (d < 64) begin
      m_two = (d / 8) % 2;
    end else if (d < 128) begin
      m_aerr = 1;
    end else begin
      a = d - 128;
      if (a < 16) m_cur = a;
      else if (a >= 64 && a < 80) m_cur = a - 48;
      else m_aerr = 1;
    end
  endtask

  function automatic int exp_status();
    int s;
    s = (m_cur < 16) ? m_cur : 64 + m_cur - 16;
    if (cyc < busy_end) s += 128;
    return s;
  endfunction

  task automatic check_state();
    int idx;
    chk("cursor", cursor, m_cur);
    chk("busy", busy, cyc < busy_end);
    chk("display_on", display_on, m_dsp);
    chk("cursor_on", cursor_on, m_con);
    chk("blink_on", blink_on, m_blk);
    chk("two_line", two_line, m_two);
    chk("overrun", overrun, m_ovr);
    chk("addr_err", addr_err, m_aerr);
    chk("bus_oe_idle", bus_oe, 1'b0);
    chk("bus_out_idle", bus_out, 8'h00);
    if (cyc >= clr_edge + 32) begin
      idx = $urandom_range(0, 31);
      rd_addr = 5'(idx);
      #1;
      chk("rd_char", rd_char, m_mem[idx]);
    end
  endtask

  task automatic check_mirror();
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      chk("mirror", rd_char, m_mem[i]);
    end
  endtask

  task automatic txn(input bit r, input bit w, input logic [7:0] d,
                     input int hold);
    int p;
    @(negedge clk);
    rs = r; rw = w; data = d; en = 1'b1;
    #1;
    chk("bus_oe", bus_oe, w);
    if (w) begin
      rd_val = bus_out;
      if (!r) chk("status", bus_out, exp_status());
      else if (cyc >= clr_edge + 32)
        chk("rdata", bus_out, m_mem[m_cur]);
    end else begin
      chk("bus_out_w", bus_out, 8'h00);
    end
    repeat (hold) @(negedge clk);
    en = 1'b0;
    data = 8'($urandom);
    rs = 1'($urandom);
    rw = 1'($urandom);
    p = cyc + 1;
    model_strobe(r, w, int'(d), p);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic wr_i(input logic [7:0] d);
    txn(1'b0, 1'b0, d, 1);
    wait_idle();
  endtask

  task automatic wr_d(input logic [7:0] d);
    txn(1'b1, 1'b0, d, 1);
    wait_idle();
  endtask

  initial begin
    int n;
    int kind;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    check_mirror();
    @(negedge clk);
    reset = 1'b0;

    wr_i(8'h38); wr_i(8'h0C); wr_i(8'h06);
    wr_d(8'h48); wr_d(8'h49);
    rd_addr = 5'd0; #1; chk("hi_0", rd_char, 8'h48);
    rd_addr = 5'd1; #1; chk("hi_1", rd_char, 8'h49);
    chk("hi_cur", cursor, 5'd2);
    chk("hi_dsp", display_on, 1'b1);
    chk("hi_con", cursor_on, 1'b0);
    chk("hi_two", two_line, 1'b1);

    wr_i(8'hC5);
    txn(1'b1, 1'b0, 8'h37, 1);
    txn(1'b0, 1'b1, 8'h00, 1);
    chk("st_busy", rd_val, 8'hC6);
    wait_idle();
    txn(1'b0, 1'b1, 8'h00, 1);
    chk("st_idle", rd_val, 8'h46);
    rd_addr = 5'd21; #1; chk("l2_cell", rd_char, 8'h37);
    chk("l2_cur", cursor, 5'd22);

    wr_i(8'h8F);
    wr_d(8'h41); chk("wrap_a", cursor, 5'd16);
    wr_d(8'h42); chk("wrap_b", cursor, 5'd17);
    wr_i(8'h04); wr_i(8'h80);
    wr_d(8'h5A); chk("wrap_dn", cursor, 5'd31);
    wr_i(8'h06);
    txn(1'b1, 1'b1, 8'h00, 1);
    wait_idle();

    wr_i(8'h80);
    for (int i = 0; i < 5; i++) wr_d(8'h61 + 8'(i));
    txn(1'b0, 1'b0, 8'h01, 1);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("clr_busy_len", n, BL);
    check_mirror();
    chk("clr_cur", cursor, 5'd0);

    txn(1'b1, 1'b0, 8'h31, 4);
    repeat (10) @(posedge clk);
    txn(1'b1, 1'b0, 8'h32, 1);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_cur", cursor, 5'd1);
    rd_addr = 5'd1; #1; chk("ovr_cell", rd_char, 8'h20);
    wait_idle();

    wr_i(8'h95);
    chk("aerr_flag", addr_err, 1'b1);
    chk("aerr_cur", cursor, 5'd1);

    txn(1'b1, 1'b0, 8'h77, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_aerr", addr_err, 1'b0);
    chk("rst_cur", cursor, 5'd0);
    check_mirror();
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 3);
      txn(kind[0], kind[1], 8'($urandom), $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) wait_idle();
      else repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle();
    check_mirror();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
